// File: rtl/conv2d_mem_if_mc_if.sv
// Handshake bundle between the conv2d engine, the memory system and the compute unit.
// master = engine side, slave = memory / compute side.
interface conv2d_mem_if_mc_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic [AWIDTH-1:0] req_read_addr;
    logic              req_read_addr_valid;
    logic              req_read_addr_ready;
    logic [31:0]       req_read_len;
    logic [AWIDTH-1:0] req_write_addr;
    logic              req_write_addr_valid;
    logic              req_write_addr_ready;
    logic [31:0]       req_write_len;
    logic [DWIDTH-1:0] req_write_data;
    logic              req_write_data_valid;
    logic              req_write_data_ready;
    logic              resp_write_status;
    logic              resp_write_status_valid;
    logic              resp_write_status_ready;
    logic [DWIDTH-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;

    modport master (
        output req_read_addr, req_read_addr_valid, req_read_len,
        input  req_read_addr_ready,
        output req_write_addr, req_write_addr_valid, req_write_len,
        input  req_write_addr_ready,
        output req_write_data, req_write_data_valid,
        input  req_write_data_ready,
        input  resp_write_status, resp_write_status_valid,
        output resp_write_status_ready,
        input  wdata, wdata_valid,
        output wdata_ready
    );

    modport slave (
        input  req_read_addr, req_read_addr_valid, req_read_len,
        output req_read_addr_ready,
        input  req_write_addr, req_write_addr_valid, req_write_len,
        output req_write_addr_ready,
        input  req_write_data, req_write_data_valid,
        output req_write_data_ready,
        output resp_write_status, resp_write_status_valid,
        input  resp_write_status_ready,
        output wdata, wdata_valid,
        input  wdata_ready
    );
endinterface

// File: rtl/conv2d_mem_if_mc.sv
// Conv2d memory sequencer: weight fetch, halo-aware IFM fetch, buffered OFM writes.
// Define CONV2D_BURST_WT_EN to fetch all weights with a single burst request.
module conv2d_mem_if_mc #(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int WT_DIM      = 3,
    parameter int NUM_CH      = 1,
    parameter int WR_LOGDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        idle,
    output logic        done,
    output logic        wr_err,
    input  logic [31:0] fm_dim,
    input  logic [31:0] stride,
    input  logic [31:0] wt_offset,
    input  logic [31:0] ifm_offset,
    input  logic [31:0] ofm_offset,
    conv2d_mem_if_mc_if.master mem,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [31:0] ch
);
`ifdef CONV2D_BURST_WT_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam int TOTAL = NUM_CH * WT_DIM * WT_DIM;
    localparam int KW    = $clog2(WT_DIM + 1);
    localparam int CW    = $clog2(NUM_CH + 1);
    localparam int WIW   = $clog2(TOTAL + 1);
    localparam int DEPTH = 2 ** WR_LOGDEPTH;
    localparam logic [KW-1:0]  K_LAST  = KW'(WT_DIM - 1);
    localparam logic [CW-1:0]  C_LAST  = CW'(NUM_CH - 1);
    localparam logic [WIW-1:0] WI_LAST = WIW'(TOTAL - 1);
    localparam logic [33:0]    HALF    = 34'(WT_DIM / 2);

    typedef enum logic [2:0] {
        IDLE, READ_WT, READ_IFM, WRITE_OFM, DRAIN
    } state_t;

    state_t state, state_nx;

    logic [31:0]    fm_q, wt_off_q, ifm_off_q, ofm_off_q;
    logic [1:0]     step_q;
    logic [WIW-1:0] wi_q;
    logic [CW-1:0]  c_q;
    logic [KW-1:0]  m_q, n_q;
    logic [31:0]    x_q, y_q, ofm_cnt_q, outst_q;
    logic           wr_err_q;

    logic [AWIDTH-1:0]      aw_mem [DEPTH];
    logic [DWIDTH-1:0]      wd_mem [DEPTH];
    logic [WR_LOGDEPTH:0]   aw_wp, aw_rp, wd_wp, wd_rp;
    logic aw_full, aw_empty, wd_full, wd_empty;

    logic              rd_valid;
    logic [AWIDTH-1:0] rd_addr;
    logic [31:0]       rd_len;
    logic start_ok, wt_last, halo, ifm_adv, last_elem;
    logic wr_fire, aw_fire, wd_fire, resp_fire;
    logic x_wrap, y_end, drained;
    logic [33:0] idx34, idy34;
    logic [31:0] ifm_addr;

    assign start_ok  = start && (fm_dim != 32'd0);
    assign wt_last   = BURST || (wi_q == WI_LAST);
    assign last_elem = (c_q == C_LAST) && (m_q == K_LAST) && (n_q == K_LAST);

    // Window coordinates go negative at the top/left edge; bit 33 flags that.
    assign idx34 = {2'b00, x_q} + 34'(n_q) - HALF;
    assign idy34 = {2'b00, y_q} + 34'(m_q) - HALF;
    assign halo  = idx34[33] || idy34[33]
                || (idx34[32:0] >= {1'b0, fm_q})
                || (idy34[32:0] >= {1'b0, fm_q});
    assign ifm_addr = ifm_off_q
                    + 32'(c_q) * fm_q * fm_q
                    + idy34[31:0] * fm_q
                    + idx34[31:0];

    assign x_wrap  = ({1'b0, x_q} + 33'(step_q)) >= {1'b0, fm_q};
    assign y_end   = ({1'b0, y_q} + 33'(step_q)) >= {1'b0, fm_q};
    assign drained = aw_empty && wd_empty && (outst_q == 32'd0);

    assign ifm_adv   = (state == READ_IFM) && (halo || mem.req_read_addr_ready);
    assign wr_fire   = mem.wdata_valid && mem.wdata_ready;
    assign aw_fire   = mem.req_write_addr_valid && mem.req_write_addr_ready;
    assign wd_fire   = mem.req_write_data_valid && mem.req_write_data_ready;
    assign resp_fire = mem.resp_write_status_valid;

    always_comb begin
        state_nx = state;
        rd_valid = 1'b0;
        rd_addr  = '0;
        rd_len   = 32'd1;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nx = READ_WT;
            end
            READ_WT: begin
                rd_valid = 1'b1;
                rd_addr  = BURST ? AWIDTH'(wt_off_q)
                                 : AWIDTH'(wt_off_q + 32'(wi_q));
                rd_len   = BURST ? 32'(TOTAL) : 32'd1;
                if (mem.req_read_addr_ready && wt_last) state_nx = READ_IFM;
            end
            READ_IFM: begin
                rd_valid = !halo;
                rd_addr  = AWIDTH'(ifm_addr);
                if (ifm_adv && last_elem) state_nx = WRITE_OFM;
            end
            WRITE_OFM: begin
                if (wr_fire) state_nx = (x_wrap && y_end) ? DRAIN : READ_IFM;
            end
            DRAIN: begin
                if (drained) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem.req_read_addr         = rd_addr;
    assign mem.req_read_addr_valid   = rd_valid;
    assign mem.req_read_len          = rd_len;
    assign mem.req_write_addr        = aw_mem[aw_rp[WR_LOGDEPTH-1:0]];
    assign mem.req_write_addr_valid  = !aw_empty;
    assign mem.req_write_len         = 32'd1;
    assign mem.req_write_data        = wd_mem[wd_rp[WR_LOGDEPTH-1:0]];
    assign mem.req_write_data_valid  = !wd_empty;
    assign mem.resp_write_status_ready = 1'b1;
    assign mem.wdata_ready = (state == WRITE_OFM) && !aw_full && !wd_full;

    assign idle   = (state == IDLE);
    assign done   = (state == DRAIN) && drained;
    assign wr_err = wr_err_q;
    assign x      = x_q;
    assign y      = y_q;
    assign ch     = 32'(c_q);

    assign aw_empty = (aw_wp == aw_rp);
    assign wd_empty = (wd_wp == wd_rp);
    assign aw_full  = (aw_wp[WR_LOGDEPTH] != aw_rp[WR_LOGDEPTH])
                   && (aw_wp[WR_LOGDEPTH-1:0] == aw_rp[WR_LOGDEPTH-1:0]);
    assign wd_full  = (wd_wp[WR_LOGDEPTH] != wd_rp[WR_LOGDEPTH])
                   && (wd_wp[WR_LOGDEPTH-1:0] == wd_rp[WR_LOGDEPTH-1:0]);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            aw_mem[aw_wp[WR_LOGDEPTH-1:0]] <= AWIDTH'(ofm_off_q + ofm_cnt_q);
            wd_mem[wd_wp[WR_LOGDEPTH-1:0]] <= mem.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fm_q      <= '0;
            wt_off_q  <= '0;
            ifm_off_q <= '0;
            ofm_off_q <= '0;
            step_q    <= 2'd1;
            wi_q      <= '0;
            c_q       <= '0;
            m_q       <= '0;
            n_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ofm_cnt_q <= '0;
            outst_q   <= '0;
            wr_err_q  <= 1'b0;
            aw_wp     <= '0;
            aw_rp     <= '0;
            wd_wp     <= '0;
            wd_rp     <= '0;
        end else begin
            state <= state_nx;
            if (state == READ_WT && mem.req_read_addr_ready)
                wi_q <= wi_q + WIW'(1);
            if (ifm_adv) begin
                n_q <= (n_q == K_LAST) ? '0 : n_q + KW'(1);
                if (n_q == K_LAST) begin
                    m_q <= (m_q == K_LAST) ? '0 : m_q + KW'(1);
                    if (m_q == K_LAST)
                        c_q <= (c_q == C_LAST) ? '0 : c_q + CW'(1);
                end
            end
            if (wr_fire) begin
                ofm_cnt_q <= ofm_cnt_q + 32'd1;
                aw_wp     <= aw_wp + (WR_LOGDEPTH+1)'(1);
                wd_wp     <= wd_wp + (WR_LOGDEPTH+1)'(1);
                if (x_wrap) begin
                    x_q <= '0;
                    y_q <= y_q + 32'(step_q);
                end else begin
                    x_q <= x_q + 32'(step_q);
                end
            end
            if (aw_fire) aw_rp <= aw_rp + (WR_LOGDEPTH+1)'(1);
            if (wd_fire) wd_rp <= wd_rp + (WR_LOGDEPTH+1)'(1);
            unique case ({aw_fire, resp_fire})
                2'b10:   outst_q <= outst_q + 32'd1;
                2'b01:   outst_q <= outst_q - 32'd1;
                default: outst_q <= outst_q;
            endcase
            if (resp_fire && !mem.resp_write_status) wr_err_q <= 1'b1;
            if (state == IDLE && start_ok) begin
                fm_q      <= fm_dim;
                wt_off_q  <= wt_offset;
                ifm_off_q <= ifm_offset;
                ofm_off_q <= ofm_offset;
                step_q    <= (stride == 32'd2) ? 2'd2 : 2'd1;
                wi_q      <= '0;
                c_q       <= '0;
                m_q       <= '0;
                n_q       <= '0;
                x_q       <= '0;
                y_q       <= '0;
                ofm_cnt_q <= '0;
                wr_err_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv2d_mem_if_mc.sv
// Scoreboard bench for conv2d_mem_if_mc: random handshakes against a loop-level model.
// Expected traffic is queued at job start; a negedge monitor pops and compares.
module tb_conv2d_mem_if_mc;
    localparam int K    = 3;
    localparam int NCH  = 2;
    localparam int LOGD = 4;
    localparam int TOT  = NCH * K * K;
`ifdef CONV2D_BURST_WT_EN
    localparam int WT_REQS = 1;
`else
    localparam int WT_REQS = TOT;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, idle, done, wr_err;
    logic [31:0] fm_dim, stride, wt_offset, ifm_offset, ofm_offset;
    logic [31:0] x, y, ch;

    rd_t         rd_q[$];
    logic [31:0] aw_q[$];
    logic [31:0] wd_q[$];
    logic [63:0] ctr_q[$];

    int tests, fails;
    int done_cnt, wr_fires, rd_fires, pending, exp_rd;
    bit rnd, aw_block, inject_err, in_reset;

    always #5 clk = ~clk;

    conv2d_mem_if_mc_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    conv2d_mem_if_mc #(
        .AWIDTH(32), .DWIDTH(32), .WT_DIM(K),
        .NUM_CH(NCH), .WR_LOGDEPTH(LOGD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start(start), .idle(idle), .done(done), .wr_err(wr_err),
        .fm_dim(fm_dim), .stride(stride),
        .wt_offset(wt_offset), .ifm_offset(ifm_offset),
        .ofm_offset(ofm_offset),
        .mem(bus),
        .x(x), .y(y), .ch(ch)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every fire is compared against the front of its queue.
    always @(negedge clk) begin
        rd_t re;
        if (rst_n) begin
            if (bus.req_read_addr_valid && bus.req_read_addr_ready) begin
                rd_fires++;
                check("rd_expected", 64'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) begin
                    re = rd_q.pop_front();
                    check("rd_addr", 64'(bus.req_read_addr), 64'(re.addr));
                    check("rd_len", 64'(bus.req_read_len), 64'(re.len));
                end
            end
            if (bus.req_write_addr_valid && bus.req_write_addr_ready) begin
                pending++;
                check("aw_expected", 64'(aw_q.size() != 0), 1);
                if (aw_q.size() != 0)
                    check("aw_addr", {bus.req_write_len, bus.req_write_addr},
                          {32'd1, aw_q.pop_front()});
            end
            if (bus.req_write_data_valid && bus.req_write_data_ready) begin
                check("wd_expected", 64'(wd_q.size() != 0), 1);
                if (wd_q.size() != 0)
                    check("wd_data", 64'(bus.req_write_data), 64'(wd_q.pop_front()));
            end
            if (bus.wdata_valid && bus.wdata_ready) begin
                wr_fires++;
                check("ctr_expected", 64'(ctr_q.size() != 0), 1);
                if (ctr_q.size() != 0)
                    check("centre_xy", {x, y}, ctr_q.pop_front());
                wd_q.push_back(bus.wdata);
            end
            if (done) done_cnt++;
        end
    end

    // Memory / compute-side driver, updated just after each rising edge.
    initial begin
        bus.req_read_addr_ready     = 1'b0;
        bus.req_write_addr_ready    = 1'b0;
        bus.req_write_data_ready    = 1'b0;
        bus.resp_write_status       = 1'b1;
        bus.resp_write_status_valid = 1'b0;
        bus.wdata                   = '0;
        bus.wdata_valid             = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && bus.resp_write_status_valid && bus.resp_write_status_ready)
                pending--;
            bus.req_read_addr_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.req_write_addr_ready = aw_block ? 1'b0
                                     : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            bus.req_write_data_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.wdata_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.wdata       = $urandom;
            if (!in_reset && pending > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
                bus.resp_write_status_valid = 1'b1;
                bus.resp_write_status       = !inject_err;
                inject_err = 1'b0;
            end else begin
                bus.resp_write_status_valid = 1'b0;
                bus.resp_write_status       = 1'b1;
            end
        end
    end

    // Reference: walk output centres and kernel taps, keep in-bounds taps.
    task automatic start_job(input int fm, input int sd);
        int s, od, cx, cy, ix, iy, k;
        rd_t e;
        done_cnt = 0;
        wr_fires = 0;
        rd_fires = 0;
        s  = (sd == 2) ? 2 : 1;
        od = (fm - 1) / s + 1;
        fm_dim     = fm;
        stride     = sd;
        wt_offset  = $urandom;
        ifm_offset = $urandom;
        ofm_offset = $urandom;
`ifdef CONV2D_BURST_WT_EN
        e.addr = wt_offset;
        e.len  = TOT;
        rd_q.push_back(e);
`else
        for (int i = 0; i < TOT; i++) begin
            e.addr = wt_offset + i;
            e.len  = 1;
            rd_q.push_back(e);
        end
`endif
        k = 0;
        for (int oy = 0; oy < od; oy++) begin
            for (int ox = 0; ox < od; ox++) begin
                cx = ox * s;
                cy = oy * s;
                for (int c = 0; c < NCH; c++)
                    for (int m = 0; m < K; m++)
                        for (int n = 0; n < K; n++) begin
                            ix = cx - K / 2 + n;
                            iy = cy - K / 2 + m;
                            if (ix >= 0 && ix < fm && iy >= 0 && iy < fm) begin
                                e.addr = ifm_offset + 32'(c * fm * fm + iy * fm + ix);
                                e.len  = 1;
                                rd_q.push_back(e);
                            end
                        end
                ctr_q.push_back({32'(cx), 32'(cy)});
                aw_q.push_back(ofm_offset + 32'(k));
                k++;
            end
        end
        exp_rd = rd_q.size();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_job(input bit exp_err);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 64'(done_cnt), 1);
        check("rd_count", 64'(rd_fires), 64'(exp_rd));
        check("rd_left", 64'(rd_q.size()), 0);
        check("aw_left", 64'(aw_q.size()), 0);
        check("wd_left", 64'(wd_q.size()), 0);
        check("idle_after", 64'(idle), 1);
        check("wr_err", 64'(wr_err), 64'(exp_err));
    endtask

    task automatic run_job(input int fm, input int sd, input bit exp_err,
                           input bit poke);
        start_job(fm, sd);
        if (poke) begin
            repeat (30) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        finish_job(exp_err);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        tests = 0; fails = 0;
        done_cnt = 0; wr_fires = 0; rd_fires = 0; pending = 0; exp_rd = 0;
        rnd = 1'b0; aw_block = 1'b0; inject_err = 1'b0; in_reset = 1'b0;
        rst_n = 1'b0; start = 1'b0;
        fm_dim = '0; stride = '0; wt_offset = '0; ifm_offset = '0; ofm_offset = '0;
        #12;
        check("rst_idle", 64'(idle), 1);
        check("rst_done", 64'(done), 0);
        check("rst_wr_err", 64'(wr_err), 0);
        check("rst_valids", {bus.req_read_addr_valid, bus.req_write_addr_valid,
                             bus.req_write_data_valid, bus.wdata_ready}, 0);
        check("resp_ready", 64'(bus.resp_write_status_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        fm_dim = 0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("zero_dim_idle", 64'(idle), 1);
        check("zero_dim_no_rd", 64'(bus.req_read_addr_valid), 0);

        run_job(4, 1, 1'b0, 1'b1);
        run_job(5, 2, 1'b0, 1'b0);
        run_job(1, 1, 1'b0, 1'b0);

        rnd = 1'b1;
        for (int i = 0; i < 4; i++)
            run_job(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                    1'b0, 1'b0);

        rnd = 1'b0;
        aw_block = 1'b1;
        inject_err = 1'b1;
        wr_fires = 0;
        fork
            run_job(5, 1, 1'b1, 1'b0);
            begin
                int c2;
                c2 = 0;
                while (wr_fires < 16 && c2 < 5000) begin
                    @(posedge clk);
                    c2++;
                end
                repeat (40) @(posedge clk);
                #1;
                check("bp_writes_held", 64'(wr_fires), 16);
                check("bp_wdata_ready", 64'(bus.wdata_ready), 0);
                check("bp_aw_valid", 64'(bus.req_write_addr_valid), 1);
                aw_block = 1'b0;
            end
        join
        run_job(3, 1, 1'b0, 1'b0);

        rnd = 1'b1;
        start_job(6, 1);
        cyc = 0;
        while (rd_fires < WT_REQS + 5 && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_reset = 1'b1;
        #1;
        check("rst_mid_idle", 64'(idle), 1);
        check("rst_mid_valids", {bus.req_read_addr_valid, bus.req_write_addr_valid,
                                 bus.req_write_data_valid, bus.wdata_ready, done}, 0);
        check("rst_mid_xyc", {x, y, ch}, 0);
        rd_q.delete();
        aw_q.delete();
        wd_q.delete();
        ctr_q.delete();
        pending = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_reset = 1'b0;
        run_job(4, 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv2d_mem_if_mc.md
CONV2D_MEM_IF_MC -- requirements
Module: conv2d_mem_if_mc

Interface
REQ-001 SHALL have parameters: AWIDTH, 32, address width; DWIDTH, 32, data width; WT_DIM, 3, odd kernel edge; NUM_CH, 1, input channels (1..16); WR_LOGDEPTH, 4, log2 depth of write addr/data FIFOs.
REQ-002 SHALL have ports, in order: clk in 1 clock; rst_n in 1 reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have control ports: start in 1; idle out 1; done out 1 one-cycle pulse; wr_err out 1 sticky write-error flag.
REQ-004 SHALL have scalar inputs, all 32 bits: fm_dim; stride (1 or 2); wt_offset; ifm_offset; ofm_offset.
REQ-005 SHALL have the read channel: req_read_addr out AWIDTH; req_read_addr_valid out 1; req_read_addr_ready in 1; req_read_len out 32.
REQ-006 SHALL have the write channels: req_write_addr/_valid/_ready (AWIDTH,1,1); req_write_len out 32; req_write_data/_valid/_ready (DWIDTH,1,1); resp_write_status/_valid in 1; resp_write_status_ready out 1.
REQ-007 SHALL have compute-side ports: x, y, ch out 32 (current window centre, channel); wdata in DWIDTH; wdata_valid in 1; wdata_ready out 1.

Function
REQ-008 States SHALL be IDLE, READ_WT, READ_IFM, WRITE_OFM, DRAIN; idle=1 only in IDLE.
REQ-009 IDLE->READ_WT on start with fm_dim!=0; start SHALL be ignored outside IDLE or when fm_dim==0.
REQ-010 Weight index SHALL loop c (outer), m, n (inner) over 0..NUM_CH-1, 0..WT_DIM-1; address = wt_offset + c*WT_DIM*WT_DIM + m*WT_DIM + n.
REQ-011 READ_WT->READ_IFM on the final weight request fire.
REQ-012 READ_IFM SHALL iterate (c,m,n) per window; idx=x-WT_DIM/2+n, idy=y-WT_DIM/2+m (signed); halo when idx<0, idx>=fm_dim, idy<0 or idy>=fm_dim.
REQ-013 Non-halo element SHALL issue one request at ifm_offset + c*fm_dim*fm_dim + idy*fm_dim + idx, advancing on fire; halo element SHALL advance in one cycle with valid low.
REQ-014 READ_IFM->WRITE_OFM after the last (c,m,n) element advances; req_read_len SHALL be 1 for IFM reads.
REQ-015 wdata_ready SHALL equal (state==WRITE_OFM) & both FIFOs not full; a write SHALL occur on wdata_valid & wdata_ready, enqueuing address ofm_offset + ofm_cnt and wdata.
REQ-016 ofm_cnt SHALL start at 0 and increment per write; x SHALL step by stride, wrapping to 0 and stepping y by stride when x+stride>=fm_dim.
REQ-017 After a write, state SHALL return to READ_IFM, or enter DRAIN if y+stride>=fm_dim and the x-wrap occurs.
REQ-018 Outstanding-write counter SHALL increment on write-address dequeue fire, decrement on resp_write_status fire, both same cycle = unchanged.
REQ-019 resp_write_status_ready SHALL be 1; resp with status 0 SHALL set wr_err until next accepted start.
REQ-020 DRAIN->IDLE when both FIFOs empty and outstanding==0; done SHALL pulse that cycle.
REQ-021 req_write_len SHALL be 1; stride values other than 2 SHALL behave as 1.
REQ-022 Output dimension SHALL be (fm_dim-1)/stride+1 per axis (integer division).

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, all counters 0, FIFOs empty, wr_err=0, done=0, all valids=0, idle=1.
REQ-024 rst_n asserted mid-operation SHALL abandon all in-flight requests without further handshakes.

Configuration
REQ-025 With CONV2D_BURST_WT_EN defined, READ_WT SHALL issue a single request at wt_offset with req_read_len=NUM_CH*WT_DIM*WT_DIM, then go to READ_IFM on its fire; without it, one request per weight with req_read_len=1.

Verification
REQ-026 fm_dim=4, NUM_CH=1, stride=1, ready always 1 -> 9 weight reads, 16 writes at ofm_offset+0..15, done pulses once.
REQ-027 Window (0,0), WT_DIM=3 -> only 4 IFM requests (idx,idy in {0,1}), 5 halo cycles with valid low.
REQ-028 fm_dim=5, stride=2 -> 9 writes at ofm_offset+0..8, centres x,y in {0,2,4}.
REQ-029 NUM_CH=2, burst macro defined -> one request, req_read_len=18; undefined -> 18 requests, len 1.
REQ-030 req_write_addr_ready held 0 for 40 cycles -> wdata_ready drops at FIFO full, no lost data; one resp status 0 -> wr_err=1, done still pulses.
REQ-031 rst_n low during READ_IFM -> idle=1 immediately, all valids 0; new start runs a clean job.
